fetch: RTL
==========

Name: fetch

Overview:
- Instruction fetch stage, directly upstream of decode.
- Keeps the fetch PC and issues word requests on a pipelined instruction-memory port.
- Pairs each returned word with its PC and presents {pc, next_pc, instruction, valid} to decode.
- Honours hazard stall/invalidate, takes redirects from execute (branch/jump) and from trap/mret logic, and discards stale in-flight responses after a redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; also the response buffer depth (power of two, ≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_address  out  32  word address of request, bits[1:0]=0
- imem_resp_valid  in  1  response data valid; responses return in order; no backpressure
- imem_resp_data  in  32  instruction word
- stall  in  1  from hazard: hold outputs
- invalidate  in  1  from hazard: next loaded output slot is a bubble
- branch_taken  in  1  redirect from execute
- branch_target  in  32  redirect target from execute
- trap_redirect  in  1  redirect from exception/mret logic
- trap_target  in  32  redirect target from exception/mret logic
- pc_out  out  32  PC of presented instruction
- next_pc_out  out  32  pc_out+4
- instruction_out  out  32  instruction word
- valid_out  out  1  output slot holds a real instruction

Behaviour:
- Reset (rst_n=0, async):
  - fetch_pc=RESET_VECTOR, resp_pc=RESET_VECTOR.
  - outstanding=0, drop=0, buffer empty.
  - valid_out=0, pc_out=0, next_pc_out=0, instruction_out=32'h00000013 (NOP).
  - imem_req_valid=0 while in reset and in the first cycle after release.
- Redirect:
  - redirect = trap_redirect | branch_taken; target = trap_target if trap_redirect, else branch_target; target[1:0] forced to 00.
  - Redirect wins over every other event in the same cycle.
  - On redirect: fetch_pc=target, resp_pc=target, buffer flushed, valid_out=0 (even if stall=1), drop = outstanding_after_this_cycle.
  - A request handshaking in the redirect cycle is counted as outstanding and dropped. No request is issued in the redirect cycle.
- Request:
  - imem_req_valid = !redirect & (outstanding + buffer_count < MAX_OUTSTANDING).
  - imem_req_address = fetch_pc.
  - On a valid&ready handshake: fetch_pc += 4 (wraps mod 2^32), outstanding++.
  - Request may not depend combinationally on imem_resp_valid.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop>0: drop--, word discarded.
  - Otherwise push {resp_pc, data} and resp_pc += 4.
  - The credit rule guarantees the buffer never overflows; overflow is an assertion failure.
  - Handshake and response in the same cycle: outstanding unchanged.
- Output register, updated only when stall=0 and no redirect:
  - If invalidate=1 or buffer empty: valid_out=0, data fields hold.
  - Otherwise pop head: pc_out=head.pc, next_pc_out=head.pc+4, instruction_out=head.instr, valid_out=1.
  - Bypass allowed: a response arriving with the buffer empty may load the output directly in the same edge.
  - Minimum latency: request handshake cycle N, response cycle N+1, valid_out at edge ending N+1.
- stall=1: all outputs hold; requests continue while credit remains; responses keep filling the buffer.
- invalidate and stall both high: stall wins (hold).
- Back-to-back responses with stall low: one instruction per cycle; sustained throughput 1 IPC with single-cycle memory and MAX_OUTSTANDING≥2.

Decomposition:
- Shared params include: NOP encoding 32'h00000013, instruction width, RESET_VECTOR default (alongside the ALU/WRITE_SEL constants).
- One sub-module: fetch_buffer.
  - Synchronous FIFO of {pc[31:0], instr[31:0]}, depth MAX_OUTSTANDING.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, words = address → valid_out rises at third edge after release; pc_out 0,4,8,… consecutive cycles; next_pc_out = pc_out+4.
- stall held 3 cycles while responses arrive → outputs frozen; imem_req_valid drops once outstanding+buffered=2; after release, PCs continue without gap or duplicate.
- branch_taken=1, target 0x100, with 2 requests in flight → both stale responses discarded; next valid_out has pc_out=0x100; valid_out=0 in the redirect cycle even with stall=1.
- trap_redirect (0x80) and branch_taken (0x200) in the same cycle → next fetch address 0x80.
- invalidate pulse for 1 cycle with buffered instruction at 0x10 → bubble that cycle; 0x10 presented the following cycle, not lost.
- fetch_pc = 0xFFFFFFFC → next request address 0x00000000; branch_target 0x103 → request address 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage and its neighbours in the core.
package fetch_pkg;

  localparam int          XLEN                 = 32;
  localparam int          ILEN                 = 32;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    WRITE_SEL_ALU, WRITE_SEL_MEM, WRITE_SEL_PC4, WRITE_SEL_CSR
  } write_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding returned {pc, instr} pairs until decode takes them.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fetch_entry_t                 head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (pop_i)  rd_q <= bump(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
  end

  // Credit accounting upstream must make these impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      if (push_i && !pop_i) assert (count_q < CW'(DEPTH));
      if (pop_i) assert (count_q != '0);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC generation, credit-limited imem requests, response
// pairing with PCs, stale-response dropping after redirects, decode output register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_address,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_redirect,
  input  logic [31:0] trap_target,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          redirect;
  logic [31:0]   target;
  logic          started_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d, buf_count;
  logic [CW:0]   in_use;
  logic          req_fire, resp_keep, load, bypass, buf_push, buf_pop;
  fetch_entry_t  buf_head, resp_entry;
  logic          valid_q;
  logic [31:0]   pc_q, next_pc_q, instr_q;

  assign redirect = trap_redirect | branch_taken;
  assign target   = align_word(trap_redirect ? trap_target : branch_target);

  // Buffered words still hold credit until decode consumes them.
  assign in_use           = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid   = started_q & ~redirect & (in_use < (CW+1)'(MAX_OUTSTANDING));
  assign imem_req_address = fetch_pc_q;
  assign req_fire         = imem_req_valid & imem_req_ready;

  assign resp_keep  = imem_resp_valid & (drop_q == '0);
  assign resp_entry = {resp_pc_q, imem_resp_data};
  assign load       = ~redirect & ~stall & ~invalidate;
  assign buf_pop    = load & (buf_count != '0);
  assign bypass     = load & (buf_count == '0) & resp_keep;
  assign buf_push   = resp_keep & ~redirect & ~bypass;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = outstanding_d;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
      else if (imem_resp_valid) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_q        <= '0;
      valid_q       <= 1'b0;
      pc_q          <= '0;
      next_pc_q     <= '0;
      instr_q       <= NOP_INSTR;
    end else begin
      started_q     <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      if (redirect) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        if (buf_pop) begin
          valid_q   <= 1'b1;
          pc_q      <= buf_head.pc;
          next_pc_q <= buf_head.pc + 32'd4;
          instr_q   <= buf_head.instr;
        end else if (bypass) begin
          valid_q   <= 1'b1;
          pc_q      <= resp_pc_q;
          next_pc_q <= resp_pc_q + 32'd4;
          instr_q   <= imem_resp_data;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (buf_push),
    .entry_i (resp_entry),
    .pop_i   (buf_pop),
    .count_o (buf_count),
    .head_o  (buf_head)
  );

  assign pc_out          = pc_q;
  assign next_pc_out     = next_pc_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule
